// File: rtl/parity_arb_pkg.sv
// Shared definitions for parity_arbiter: FSM encoding, requester ids and default word width.
package parity_arb_pkg;

  localparam int unsigned WIDTH_DEFAULT = 3;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    SAMPLE = 3'd3,
    HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic. PARITY_ARB_ROUND_ROBIN_EN selects round-robin with a last_id
// register; otherwise requester 0 has fixed priority.
module rr_arbiter2
  import parity_arb_pkg::*;
(
`ifdef PARITY_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
  input  logic accept,
`endif
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

`ifdef PARITY_ARB_ROUND_ROBIN_EN
  logic last_id;

  // Starts at requester 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_id <= ID_REQ1;
    end else if (accept) begin
      last_id <= gnt1 ? ID_REQ1 : ID_REQ0;
    end
  end

  always_comb begin
    gnt0 = valid0 && (!valid1 || (last_id == ID_REQ1));
    gnt1 = valid1 && (!valid0 || (last_id == ID_REQ0));
  end
`else
  always_comb begin
    gnt0 = valid0;
    gnt1 = valid1 && !valid0;
  end
`endif

endmodule

// File: rtl/parity_arbiter.sv
// Shares one bit-serial parity checker between two word requesters: clear, shift MSB-first,
// sample, then hold the result. Arbitration mode set by PARITY_ARB_ROUND_ROBIN_EN.
module parity_arbiter
  import parity_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             chk_bit,
  output logic             chk_reset,
  input  logic             chk_parity,
  output logic             res_valid,
  output logic             res_data,
  output logic             res_id,
  input  logic             res_ready
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    count;
  logic             id;
  logic             gnt0, gnt1, accept;
  logic             chk_bit_d, chk_reset_d, res_valid_d;

  rr_arbiter2 u_arb (
`ifdef PARITY_ARB_ROUND_ROBIN_EN
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
`endif
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CLEAR;
      CLEAR:   state_next = SHIFT;
      SHIFT:   if (count == '0) state_next = SAMPLE;
      SAMPLE:  state_next = HOLD;
      HOLD:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Checker drive and result valid are decoded one cycle ahead and registered.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    accept      = 1'b0;
    chk_bit_d   = 1'b0;
    chk_reset_d = 1'b0;
    res_valid_d = 1'b0;
    if ((state == IDLE) && reset) begin
      req0_ready = gnt0;
      req1_ready = gnt1;
    end
    accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    chk_reset_d = (state_next == CLEAR);
    res_valid_d = (state_next == HOLD);
    case (state)
      CLEAR:   chk_bit_d = word[WIDTH-1];
      SHIFT:   if (count != '0) chk_bit_d = word[count - CW'(1)];
      default: chk_bit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word      <= '0;
      id        <= ID_REQ0;
      count     <= '0;
      chk_bit   <= 1'b0;
      chk_reset <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 1'b0;
      res_id    <= 1'b0;
    end else begin
      chk_bit   <= chk_bit_d;
      chk_reset <= chk_reset_d;
      res_valid <= res_valid_d;
      if (accept) begin
        word <= gnt1 ? req1_data : req0_data;
        id   <= gnt1 ? ID_REQ1 : ID_REQ0;
      end
      if (state == CLEAR) begin
        count <= CW'(WIDTH - 1);
      end else if ((state == SHIFT) && (count != '0)) begin
        count <= count - CW'(1);
      end
      if (state == SAMPLE) begin
        res_data <= chk_parity;
        res_id   <= id;
      end
    end
  end

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed self-checking bench for parity_arbiter (WIDTH=3) with a behavioural serial checker.
module tb_parity_arbiter;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready;
  logic         chk_bit, chk_reset, chk_parity;
  logic         res_valid, res_data, res_id;
  logic         res_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int r1_cnt = 0;
  logic chk_q = 1'b1;

  parity_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .chk_bit    (chk_bit),
    .chk_reset  (chk_reset),
    .chk_parity (chk_parity),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  // Serial parity checker model; starts dirty so a missing clear is visible.
  always @(posedge clk) begin
    if (chk_reset) chk_q <= 1'b0;
    else           chk_q <= chk_q ^ chk_bit;
  end
  assign chk_parity = chk_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req1_ready) r1_cnt <= r1_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (res_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_ready(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (which ? req1_ready : req0_ready) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    reset = 1'b0;
    tick();
    tick();
    outs = {req0_ready, req1_ready, chk_bit, chk_reset, res_valid, res_data, res_id};
    tests++;
    if (outs !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0000000", outs);
    end
    reset = 1'b1;
    tick();
    outs = {req0_ready, req1_ready, chk_bit, chk_reset, res_valid, res_data, res_id};
    tests++;
    if (outs !== 7'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got %b expected 0000000", outs);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] exp_bits;
    logic [2:0]   v;
    exp_bits   = 3'b110;
    res_ready  = 1'b1;
    req0_data  = 3'b110;
    req0_valid = 1'b1;
    #1;
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_ready: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    v = {req0_ready, chk_reset, chk_bit};
    tests++;
    if (v !== 3'b010) begin
      fails++;
      $display("FAIL single_clear: ready/chk_reset/chk_bit got %b expected 010", v);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (chk_bit !== exp_bits[2-i] || chk_reset !== 1'b0) begin
        fails++;
        $display("FAIL single_shift%0d: chk_bit=%b chk_reset=%b expected %b/0", i, chk_bit, chk_reset, exp_bits[2-i]);
      end
    end
    tick();
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_sample: res_valid got %b expected 0", res_valid);
    end
    tick();
    v = {res_valid, res_data, res_id};
    tests++;
    if (v !== 3'b100) begin
      fails++;
      $display("FAIL single_result: valid/data/id got %b expected 100", v);
    end
    tick();
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_release: res_valid got %b expected 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_par;
    int         last_acc;
    bit         ok;
    exp_par   = 8'b1001_0110;
    last_acc  = 0;
    res_ready = 1'b1;
    for (int d = 0; d < 8; d++) begin
      req1_data  = W'(d);
      req1_valid = 1'b1;
      #1;
      wait_ready(1'b1, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL sweep_ready_timeout%0d: no req1_ready expected within 20 cycles", d);
      end
      if (d > 0) begin
        tests++;
        if (cyc - last_acc != 7) begin
          fails++;
          $display("FAIL sweep_spacing%0d: got %0d cycles expected 7", d, cyc - last_acc);
        end
      end
      last_acc = cyc;
      tick();
      wait_res(ok);
      tests++;
      if (!ok || res_data !== exp_par[d] || res_id !== 1'b1) begin
        fails++;
        $display("FAIL sweep_result%0d: valid=%b data=%b id=%b expected 1/%b/1", d, ok, res_data, res_id, exp_par[d]);
      end
    end
    drain();
  endtask

  task automatic test_contention();
    logic exp_id, exp_data;
    int   r1_before;
    bit   ok;
    r1_before  = r1_cnt;
    res_ready  = 1'b1;
    req0_data  = 3'b001;
    req1_data  = 3'b011;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
`ifdef PARITY_ARB_ROUND_ROBIN_EN
      exp_id = (k % 2 == 1);
`else
      exp_id = 1'b0;
`endif
      exp_data = ~exp_id;
      wait_res(ok);
      tests++;
      if (!ok || res_id !== exp_id || res_data !== exp_data) begin
        fails++;
        $display("FAIL contention%0d: valid=%b id=%b data=%b expected 1/%b/%b", k, ok, res_id, res_data, exp_id, exp_data);
      end
      tick();
    end
`ifndef PARITY_ARB_ROUND_ROBIN_EN
    tests++;
    if (r1_cnt != r1_before) begin
      fails++;
      $display("FAIL contention_starve: req1_ready asserted %0d times expected 0", r1_cnt - r1_before);
    end
`endif
    drain();
  endtask

  task automatic test_backpressure();
    logic [5:0] v;
    bit         ok;
    res_ready  = 1'b0;
    req0_data  = 3'b111;
    req0_valid = 1'b1;
    #1;
    wait_ready(1'b0, ok);
    tick();
    req1_data  = 3'b010;
    req1_valid = 1'b1;
    wait_res(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_timeout: res_valid got 0 expected 1");
    end
    for (int i = 0; i < 10; i++) begin
      v = {res_valid, res_data, res_id, req0_ready, req1_ready, chk_reset};
      tests++;
      if (v !== 6'b110000) begin
        fails++;
        $display("FAIL bp_hold%0d: valid/data/id/r0/r1/chk_reset got %b expected 110000", i, v);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    #1;
    tests++;
    if (res_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_before_accept: res_valid got %b expected 1", res_valid);
    end
    tick();
    req0_valid = 1'b1;
    #1;
    tests++;
    if (res_valid !== 1'b0 || req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_return_idle: res_valid=%b req0_ready=%b expected 0/1", res_valid, req0_ready);
    end
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    logic [6:0] outs;
    int         seen;
    bit         ok;
    res_ready  = 1'b1;
    req1_data  = 3'b111;
    req1_valid = 1'b1;
    #1;
    wait_ready(1'b1, ok);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    outs = {req0_ready, req1_ready, chk_bit, chk_reset, res_valid, res_data, res_id};
    tests++;
    if (outs !== 7'b0) begin
      fails++;
      $display("FAIL midshift_reset: outputs got %b expected 0000000", outs);
    end
    tick();
    tick();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midshift_no_result: res_valid seen %0d cycles expected 0", seen);
    end
    req0_data  = 3'b010;
    req0_valid = 1'b1;
    #1;
    wait_ready(1'b0, ok);
    tick();
    req0_valid = 1'b0;
    wait_res(ok);
    tests++;
    if (!ok || res_data !== 1'b1 || res_id !== 1'b0) begin
      fails++;
      $display("FAIL midshift_next_word: valid=%b data=%b id=%b expected 1/1/0", ok, res_data, res_id);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_contention();
    test_backpressure();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
